// File: rtl/bp_fe_pkg.sv
// Front-end shared types for the BHT sequencing controller.
// Contents: controller state enum and the update-payload struct macro.
// The payload struct width depends on the BHT index width. A package cannot take
// parameters, so the struct is declared through a macro at the point of use.

`ifndef BP_FE_DECLARE_BHT_UPD_S
`define BP_FE_DECLARE_BHT_UPD_S(idx_width_mp) \
    typedef struct packed { \
        logic [idx_width_mp-1:0] idx; \
        logic                    correct; \
    } bp_fe_bht_upd_s
`endif

package bp_fe_pkg;

    typedef enum logic [0:0] {
        e_bht_init  = 1'b0,
        e_bht_ready = 1'b1
    } bp_fe_bht_ctrl_state_e;

endpackage

// File: rtl/bp_fe_bht_ctrl_if.sv
// Bundle of the BHT controller's update, lookup and write-port signals.
// Suffixes are from the controller's point of view. The slave modport is the controller.
// The master modport is the backend, fetch and predictor side.
//   update : upd_v_i, upd_idx_i, upd_correct_i -> upd_ready_o
//   lookup : r_v_i, r_idx_i -> r_ready_o
//   control: reinit_i -> init_done_o
//   write  : w_v_o, w_idx_o, w_correct_o, w_init_o

interface bp_fe_bht_ctrl_if #(
    parameter int unsigned bht_idx_width_p = 3
);
    logic                       upd_v_i;
    logic [bht_idx_width_p-1:0] upd_idx_i;
    logic                       upd_correct_i;
    logic                       upd_ready_o;

    logic                       r_v_i;
    logic [bht_idx_width_p-1:0] r_idx_i;
    logic                       r_ready_o;

    logic                       reinit_i;
    logic                       init_done_o;

    logic                       w_v_o;
    logic [bht_idx_width_p-1:0] w_idx_o;
    logic                       w_correct_o;
    logic                       w_init_o;

    modport slave (
        input  upd_v_i, upd_idx_i, upd_correct_i, r_v_i, r_idx_i, reinit_i,
        output upd_ready_o, r_ready_o, init_done_o, w_v_o, w_idx_o, w_correct_o, w_init_o
    );

    modport master (
        output upd_v_i, upd_idx_i, upd_correct_i, r_v_i, r_idx_i, reinit_i,
        input  upd_ready_o, r_ready_o, init_done_o, w_v_o, w_idx_o, w_correct_o, w_init_o
    );
endinterface

// File: rtl/bp_fe_bht_upd_fifo.sv
// Circular update buffer with valid/ready enqueue, valid/yumi dequeue and a sync clear.
// Ports: clk_i, reset_i (async, active-low), clr_i, v_i/data_i/ready_o (in),
//        v_o/data_o/yumi_i (out).

module bp_fe_bht_upd_fifo #(
    parameter int unsigned els_p   = 4,
    parameter int unsigned width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clr_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int unsigned ptr_width_lp = $clog2(els_p);
    localparam int unsigned cnt_width_lp = ptr_width_lp + 1;

    // The extra MSB on each pointer is a wrap bit that separates full from empty.
    logic [cnt_width_lp-1:0] wptr_q, rptr_q;
    logic [width_p-1:0]      mem_q [els_p];
    logic                    empty, full, enq, deq;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp])
                   & (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0]);
    assign ready_o = ~full;
    assign v_o     = ~empty;
    assign data_o  = mem_q[rptr_q[ptr_width_lp-1:0]];
    assign enq     = v_i & ~full;
    assign deq     = yumi_i & ~empty;

    // Pointer update; clear wins over any same-cycle enqueue or dequeue.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (enq) wptr_q <= wptr_q + cnt_width_lp'(1);
            if (deq) rptr_q <= rptr_q + cnt_width_lp'(1);
        end
    end

    // Storage array.
    always_ff @(posedge clk_i) begin
        if (enq & ~clr_i) mem_q[wptr_q[ptr_width_lp-1:0]] <= data_i;
    end
endmodule

// File: rtl/bp_fe_bht_ctrl.sv
// BHT sequencing controller. It initialises every BHT entry, then drains the
// buffered branch-resolution updates to the BHT write port. Each drain is deferred
// while a fetch read targets the same index, up to a bounded number of cycles.
// Ports: clk_i, reset_i (async, active-low), bus (bp_fe_bht_ctrl_if.slave).
// Write-port outputs and ready/done flags are combinational from state, FIFO head and read inputs.

module bp_fe_bht_ctrl
    import bp_fe_pkg::*;
#(
    parameter int unsigned bht_idx_width_p = 3,
    parameter int unsigned fifo_els_p      = 4,
    parameter int unsigned max_stall_p     = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    bp_fe_bht_ctrl_if.slave bus
);
    localparam int unsigned stall_width_lp = $clog2(max_stall_p + 1);
    localparam int unsigned upd_width_lp   = bht_idx_width_p + 1;

    `BP_FE_DECLARE_BHT_UPD_S(bht_idx_width_p);

    bp_fe_bht_ctrl_state_e        state_q, state_n;
    logic [bht_idx_width_p-1:0]   init_cnt_q, init_cnt_n;
    logic [stall_width_lp-1:0]    stall_cnt_q, stall_cnt_n;

    bp_fe_bht_upd_s               upd_in, head;
    logic                         fifo_ready, fifo_v, fifo_enq, deq;
    logic                         hazard;
    logic                         w_v, w_correct, w_init, r_ready;
    logic [bht_idx_width_p-1:0]   w_idx;

    assign upd_in.idx      = bus.upd_idx_i;
    assign upd_in.correct  = bus.upd_correct_i;
    assign bus.upd_ready_o = fifo_ready & ~bus.reinit_i & reset_i;
    assign fifo_enq        = bus.upd_v_i & bus.upd_ready_o;

    bp_fe_bht_upd_fifo #(
        .els_p   (fifo_els_p),
        .width_p (upd_width_lp)
    ) upd_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (bus.reinit_i),
        .v_i     (fifo_enq),
        .data_i  (upd_in),
        .ready_o (fifo_ready),
        .v_o     (fifo_v),
        .data_o  (head),
        .yumi_i  (deq)
    );

    assign hazard = bus.r_v_i & (bus.r_idx_i == head.idx);

    // State, init counter and stall counter registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= e_bht_init;
            init_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_n;
            init_cnt_q  <= init_cnt_n;
            stall_cnt_q <= stall_cnt_n;
        end
    end

    // Next state and write-port selection.
    always_comb begin
        state_n     = state_q;
        init_cnt_n  = init_cnt_q;
        stall_cnt_n = stall_cnt_q;
        w_v         = 1'b0;
        w_idx       = '0;
        w_correct   = 1'b0;
        w_init      = 1'b0;
        r_ready     = 1'b0;
        deq         = 1'b0;

        case (state_q)
            e_bht_init: begin
                w_v        = 1'b1;
                w_init     = 1'b1;
                w_idx      = init_cnt_q;
                init_cnt_n = init_cnt_q + bht_idx_width_p'(1);
                if (init_cnt_q == {bht_idx_width_p{1'b1}}) state_n = e_bht_ready;
            end
            e_bht_ready: begin
                r_ready = 1'b1;
                if (fifo_v) begin
                    // Defer on a same-index read, but never beyond max_stall_p cycles.
                    if (~hazard | (stall_cnt_q == stall_width_lp'(max_stall_p))) begin
                        w_v         = 1'b1;
                        w_idx       = head.idx;
                        w_correct   = head.correct;
                        deq         = 1'b1;
                        stall_cnt_n = '0;
                    end else begin
                        stall_cnt_n = stall_cnt_q + stall_width_lp'(1);
                    end
                end
            end
            default: state_n = e_bht_init;
        endcase

        // Reinit suppresses this cycle's write and restarts initialisation.
        if (bus.reinit_i) begin
            w_v         = 1'b0;
            deq         = 1'b0;
            state_n     = e_bht_init;
            init_cnt_n  = '0;
            stall_cnt_n = '0;
        end
    end

    // State already sits at INIT during reset; only the write strobe needs masking.
    assign bus.w_v_o       = w_v & reset_i;
    assign bus.w_idx_o     = w_idx;
    assign bus.w_correct_o = w_correct;
    assign bus.w_init_o    = w_init;
    assign bus.r_ready_o   = r_ready;
    assign bus.init_done_o = r_ready;
endmodule

// File: tb/tb_bp_fe_bht_ctrl.sv
module tb_bp_fe_bht_ctrl;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    typedef struct {
        logic [2:0] idx;
        logic       correct;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] init_exp;
    int         n_wr;

    logic       s_wv, s_init, s_cor, s_urdy, s_rrdy, s_done;
    logic [2:0] s_idx;

    bp_fe_bht_ctrl_if #(.bht_idx_width_p(3)) bus ();

    bp_fe_bht_ctrl #(
        .bht_idx_width_p (3),
        .fifo_els_p      (4),
        .max_stall_p     (2)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample outputs after inputs settle, score writes, then clock.
    task automatic tick();
        logic exp_rdy;
        exp_t e;
        #2;
        s_wv   = bus.w_v_o;
        s_init = bus.w_init_o;
        s_cor  = bus.w_correct_o;
        s_idx  = bus.w_idx_o;
        s_urdy = bus.upd_ready_o;
        s_rrdy = bus.r_ready_o;
        s_done = bus.init_done_o;
        exp_rdy = reset_n && !bus.reinit_i && (sb.size() < 4);
        chk("upd_ready", 32'(s_urdy), 32'(exp_rdy));
        if (s_wv && s_init) begin
            chk("init_idx", 32'(s_idx), 32'(init_exp));
            chk("init_correct", 32'(s_cor), 32'(0));
            init_exp++;
        end else if (s_wv) begin
            n_wr++;
            if (sb.size() == 0) begin
                chk("spurious_write", 32'(s_wv), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("upd_idx", 32'(s_idx), 32'(e.idx));
                chk("upd_correct", 32'(s_cor), 32'(e.correct));
            end
        end
        if (bus.upd_v_i && exp_rdy) begin
            e.idx     = bus.upd_idx_i;
            e.correct = bus.upd_correct_i;
            sb.push_back(e);
        end
        if (!reset_n || bus.reinit_i) begin
            sb.delete();
            init_exp = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [2:0] idx, input logic c);
        bus.upd_v_i       = v;
        bus.upd_idx_i     = idx;
        bus.upd_correct_i = c;
    endtask

    task automatic read(input logic v, input logic [2:0] idx);
        bus.r_v_i   = v;
        bus.r_idx_i = idx;
    endtask

    initial begin
        total = 0; bad = 0; n_wr = 0; init_exp = '0;
        offer(1'b0, 3'd0, 1'b0);
        read(1'b0, 3'd0);
        bus.reinit_i = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        @(posedge clk); #1;

        // Reset state
        tick();
        chk("rst_w_v", 32'(s_wv), 32'(0));
        chk("rst_r_ready", 32'(s_rrdy), 32'(0));
        chk("rst_done", 32'(s_done), 32'(0));

        // 1: full INIT after release, then idle READY
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("init_w_v", 32'(s_wv), 32'(1));
            chk("init_w_init", 32'(s_init), 32'(1));
            chk("init_r_ready", 32'(s_rrdy), 32'(0));
            chk("init_done_low", 32'(s_done), 32'(0));
        end
        tick();
        chk("ready_done", 32'(s_done), 32'(1));
        chk("ready_r_ready", 32'(s_rrdy), 32'(1));
        chk("ready_idle_w_v", 32'(s_wv), 32'(0));

        // 4: hazard stalls twice then forces; no hazard writes at once
        offer(1'b1, 3'd3, 1'b1);
        tick();
        chk("no_bypass", 32'(s_wv), 32'(0));
        offer(1'b0, 3'd0, 1'b0);
        read(1'b1, 3'd3);
        tick(); chk("stall1", 32'(s_wv), 32'(0));
        tick(); chk("stall2", 32'(s_wv), 32'(0));
        tick(); chk("forced_write", 32'(s_wv), 32'(1));
        chk("forced_idx", 32'(s_idx), 32'(3));
        offer(1'b1, 3'd3, 1'b0);
        read(1'b1, 3'd4);
        tick();
        offer(1'b0, 3'd0, 1'b0);
        tick(); chk("nohaz_write", 32'(s_wv), 32'(1));
        chk("nohaz_correct", 32'(s_cor), 32'(0));

        // 5: reinit discards two queued updates
        read(1'b1, 3'd6);
        offer(1'b1, 3'd6, 1'b1); tick();
        offer(1'b1, 3'd7, 1'b0); tick();
        chk("pre_reinit_stall", 32'(s_wv), 32'(0));
        offer(1'b0, 3'd0, 1'b0);
        read(1'b0, 3'd0);
        bus.reinit_i = 1'b1;
        tick();
        chk("reinit_w_v", 32'(s_wv), 32'(0));
        bus.reinit_i = 1'b0;

        // 2 + 3: queue during INIT until full, drain in order after INIT
        n_wr = 0;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: offer(1'b1, 3'd5, 1'b1);
                1: offer(1'b1, 3'd2, 1'b0);
                2: offer(1'b1, 3'd1, 1'b1);
                3: offer(1'b1, 3'd4, 1'b0);
                default: offer(1'b1, 3'd6, 1'b1);
            endcase
            tick();
            chk("reinit_init_w_init", 32'(s_init), 32'(1));
            chk("reinit_done_low", 32'(s_done), 32'(0));
            if (i == 0) chk("fifo_cleared", 32'(s_urdy), 32'(1));
            if (i == 4) chk("full_in_init", 32'(s_urdy), 32'(0));
        end
        tick();
        chk("drain1_w_v", 32'(s_wv), 32'(1));
        chk("drain1_idx", 32'(s_idx), 32'(5));
        chk("full_r1", 32'(s_urdy), 32'(0));
        tick();
        chk("drain2_idx", 32'(s_idx), 32'(2));
        chk("fifth_accepted", 32'(s_urdy), 32'(1));
        offer(1'b0, 3'd0, 1'b0);
        read(1'b1, 3'd1);
        tick(); chk("drain_stall1", 32'(s_wv), 32'(0));
        tick(); chk("drain_stall2", 32'(s_wv), 32'(0));
        tick(); chk("drain_forced", 32'(s_wv), 32'(1));
        read(1'b0, 3'd0);
        tick(); tick();
        tick(); chk("drain_empty", 32'(s_wv), 32'(0));
        chk("drain_count", 32'(n_wr), 32'(5));

        // 6: reset mid-INIT at idx 4 aborts, INIT restarts at 0
        bus.reinit_i = 1'b1;
        tick();
        bus.reinit_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset_n = 1'b0;
        tick();
        chk("midinit_rst_w_v", 32'(s_wv), 32'(0));
        chk("midinit_rst_done", 32'(s_done), 32'(0));
        tick();
        chk("midinit_rst_w_v2", 32'(s_wv), 32'(0));
        reset_n = 1'b1;
        tick();
        chk("restart_w_v", 32'(s_wv), 32'(1));
        chk("restart_idx0", 32'(s_idx), 32'(0));
        for (int i = 0; i < 7; i++) tick();
        tick();
        chk("final_done", 32'(s_done), 32'(1));
        chk("final_w_v", 32'(s_wv), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_fe_bht_ctrl.md
Name: bp_fe_bht_ctrl

Overview:
Sequencing controller for the FE branch history table (BHT) used by the branch predictor wrapper.
- After reset or on request, walks every BHT index and writes the initial counter value.
- Buffers backend branch-resolution updates in a small FIFO and drains them to the BHT write port, at most one per cycle.
- Resolves same-index read/write hazards against the fetch-side read port.
- Sits between the backend update path and the predictor's w_v_i/idx_w_i/correct_i inputs, and gates the predictor's r_v_i.

Parameters:
bht_idx_width_p, "inv", BHT index width; els_lp = 2**bht_idx_width_p entries.
fifo_els_p, 4, update FIFO depth; power of 2, >= 2.
max_stall_p, 2, maximum consecutive cycles a head update may be deferred by read hazards; >= 1.
localparam ptr_width_lp = $clog2(fifo_els_p).

Ports:
clk_i  in  1  clock, rising edge.
reset_i  in  1  asynchronous, active-low reset (0 = in reset).
upd_v_i  in  1  backend update valid.
upd_idx_i  in  bht_idx_width_p  BHT index of the resolved branch.
upd_correct_i  in  1  prediction was correct.
upd_ready_o  out  1  FIFO can accept an update this cycle.
r_v_i  in  1  fetch lookup request.
r_idx_i  in  bht_idx_width_p  lookup index.
r_ready_o  out  1  lookup permitted (BHT contents valid).
reinit_i  in  1  discard pending updates and re-initialise the BHT.
w_v_o  out  1  BHT write strobe.
w_idx_o  out  bht_idx_width_p  BHT write index.
w_correct_o  out  1  update direction to the predictor.
w_init_o  out  1  write is an init write (force counter to weakly-not-taken).
init_done_o  out  1  initialisation complete.

Behaviour:
- Reset (reset_i=0), asynchronous:
  - state=INIT, init_cnt=0, FIFO empty, stall_cnt=0.
  - Outputs while in reset: w_v_o=0, r_ready_o=0, init_done_o=0, upd_ready_o=0.
- States: INIT and READY.
- INIT, one write per cycle:
  - w_v_o=1, w_init_o=1, w_idx_o=init_cnt, w_correct_o=0; init_cnt increments.
  - When init_cnt==els_lp-1, the next state is READY. INIT lasts exactly els_lp cycles.
  - r_ready_o=0 and the FIFO does not drain.
  - upd_ready_o = ~full, so updates may queue during INIT.
- READY:
  - r_ready_o=1, init_done_o=1, w_init_o=0.
  - head = FIFO head entry; hazard = r_v_i & (r_idx_i==head.idx).
  - w_v_o = ~empty & (~hazard | stall_cnt==max_stall_p). The write is combinational from head and the read inputs.
  - Dequeue when w_v_o=1; w_idx_o=head.idx, w_correct_o=head.correct.
  - stall_cnt increments on each deferred cycle and clears on dequeue. A forced write proceeds despite a hazard; the read then returns pre-update data.
- Enqueue: on upd_v_i & upd_ready_o. upd_ready_o = ~full & ~reinit_i & reset_i.
  - No bypass: an entry is written no earlier than the cycle after enqueue.
  - Enqueue and dequeue in the same cycle are allowed; count is unchanged.
  - Full: upd_ready_o=0; the offered update is held by the producer, not dropped.
  - Pointers wrap modulo fifo_els_p. Full/empty are distinguished by an extra wrap bit.
- reinit_i=1, any state, has highest priority:
  - No write occurs this cycle: w_v_o=0.
  - Next cycle: FIFO cleared, init_cnt=0, stall_cnt=0, state=INIT, init_done_o=0.
  - Holding reinit_i high restarts INIT every cycle.
- Asynchronous reset during INIT or a drain aborts immediately. No partial writes are issued afterward; a full INIT follows.

Decomposition:
- bp_fe_pkg:
  - bp_fe_bht_ctrl_state_e {e_bht_init, e_bht_ready}.
  - Struct bp_fe_bht_upd_s {idx, correct}; width is parameterised via a macro, following package practice.
- One sub-module, bp_fe_bht_upd_fifo:
  - Circular buffer with valid/ready in, valid/yumi out, and a synchronous clear.
  - Uses the same asynchronous active-low reset.
- The controller holds the FSM, init counter, stall counter and hazard logic.

Test Plan (bht_idx_width_p=3, fifo_els_p=4, max_stall_p=2):
1. Release reset -> w_v_o=1, w_init_o=1, w_idx_o=0..7 on 8 consecutive cycles; cycle 9: init_done_o=1, r_ready_o=1, w_v_o=0.
2. During INIT, enqueue idx 5/correct 1 and idx 2/correct 0 -> both held; after init, w_idx_o=5, w_correct_o=1, then w_idx_o=2, w_correct_o=0 on consecutive cycles.
3. In READY, enqueue 5 updates back-to-back while r_v_i forces hazards -> upd_ready_o=0 after 4 entries; 5th accepted only after the first dequeue; order preserved.
4. Head idx 3 with r_v_i=1, r_idx_i=3 held -> w_v_o=0 for 2 cycles, forced w_v_o=1 on the 3rd cycle; with r_idx_i=4 instead -> write on the first cycle.
5. Two updates queued, pulse reinit_i -> w_v_o=0 that cycle, FIFO empty next cycle, INIT writes idx 0..7, queued updates never written.
6. Drive reset_i=0 mid-INIT at idx 4 -> w_v_o=0 immediately; after release, INIT restarts at idx 0.
